// File: rtl/meter_ctrl.sv
// meter_ctrl: command and control engine for the voltmeter digital core.
// Decodes register read/write and action frames arriving from the SPI slave
// and drives the AFE channel, range, integrator reset and reference sign.
// Optional auto-ranging state machine: define METER_CTRL_AUTORANGE_EN to build it in.
// Without it, busy_o is tied low and the AUTORANGE opcode is treated as illegal.
module meter_ctrl #(
  parameter int DW         = 32,
  parameter int N_CH       = 4,
  parameter int N_RANGE    = 8,
  parameter int SETTLE_CYC = 64,
  parameter int RST_CYC    = 4,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int RG_W      = (N_RANGE > 1) ? $clog2(N_RANGE) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [DW-1:0]   rx_data_i,
  input  logic            rx_valid_i,
  output logic [DW-1:0]   tx_data_o,
  output logic            tx_wren_o,
  input  logic            tx_ack_i,
  input  logic            comp_i,
  input  logic            sat_hi_i,
  input  logic            sat_lo_i,
  input  logic            ref_ok_i,
  output logic [CH_W-1:0] afe_sel_o,
  output logic [RG_W-1:0] range_sel_o,
  output logic            afe_reset_o,
  output logic            ref_sign_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam logic [3:0] OP_WRITE     = 4'h1;
  localparam logic [3:0] OP_READ      = 4'h2;
  localparam logic [3:0] OP_AUTORANGE = 4'h3;
  localparam logic [3:0] OP_AFE_RST   = 4'h4;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_CHSEL   = 4'd1;
  localparam logic [3:0] ADDR_RANGE   = 4'd2;
  localparam logic [3:0] ADDR_STATUS  = 4'd3;
  localparam logic [3:0] ADDR_ID      = 4'd4;

  localparam logic [15:0] ID_VALUE    = 16'h1801;
  localparam logic [15:0] N_CH_LIM    = 16'(N_CH);
  localparam logic [15:0] N_RANGE_LIM = 16'(N_RANGE);

  // Power-up and top-of-scale range: least sensitive setting.
  localparam logic [RG_W-1:0] RANGE_TOP = RG_W'(N_RANGE - 1);

  // The integrator reset counter holds the number of high cycles still to go
  // after the current one, so it loads RST_CYC-1 on a trigger.
  localparam int             RC_W     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0] RST_LOAD = RC_W'((RST_CYC > 0) ? RST_CYC - 1 : 0);

  logic [3:0]  opcode;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic        unused_rx;

  logic is_write;
  logic is_read;
  logic is_autorange;
  logic is_afe_rst;
  logic op_illegal;

  logic ch_bad;
  logic rg_bad;
  logic wr_ctrl;
  logic wr_chsel;
  logic wr_range;
  logic frame_err;
  logic pulse_trig;

  logic [15:0]     read_value;
  logic [RC_W-1:0] rst_cnt;

  // Auto-range hooks seen by the register file; tied off when the FSM is absent.
  logic busy_q;
  logic ar_start;
  logic ar_reject;
  logic ar_up;
  logic ar_down;
  logic ar_fault;

  assign opcode = rx_data_i[DW-1 -: 4];
  assign addr   = rx_data_i[DW-5 -: 4];
  assign wdata  = rx_data_i[15:0];

  // Frame bits between the address field and the data field carry nothing.
  generate
    if (DW > 24) begin : g_gap
      assign unused_rx = ^rx_data_i[DW-9:16];
    end else begin : g_no_gap
      assign unused_rx = 1'b0;
    end
  endgenerate

  // Opcode decode, qualified by the frame strobe.
  always_comb begin
    is_write     = rx_valid_i && (opcode == OP_WRITE);
    is_read      = rx_valid_i && (opcode == OP_READ);
    is_autorange = rx_valid_i && (opcode == OP_AUTORANGE);
    is_afe_rst   = rx_valid_i && (opcode == OP_AFE_RST);
    op_illegal   = rx_valid_i && (opcode > OP_AFE_RST);
  end

  // Read mux; STATUS samples the live analog flags at decode time.
  always_comb begin
    read_value = '0;
    case (addr)
      ADDR_CTRL:   read_value = {15'd0, ref_sign_o};
      ADDR_CHSEL:  read_value = 16'(afe_sel_o);
      ADDR_RANGE:  read_value = 16'(range_sel_o);
      ADDR_STATUS: read_value = {10'd0, err_o, busy_q, ref_ok_i, sat_lo_i, sat_hi_i, comp_i};
      ADDR_ID:     read_value = ID_VALUE;
      default:     read_value = '0;
    endcase
  end

  // Write qualification and error sources; bad or busy-time selector writes are dropped.
  always_comb begin
    ch_bad     = (wdata >= N_CH_LIM);
    rg_bad     = (wdata >= N_RANGE_LIM);
    wr_ctrl    = is_write && (addr == ADDR_CTRL);
    wr_chsel   = is_write && (addr == ADDR_CHSEL) && !ch_bad && !busy_q;
    wr_range   = is_write && (addr == ADDR_RANGE) && !rg_bad && !busy_q;
    frame_err  = op_illegal || ar_reject
              || (is_write && (addr > ADDR_ID))
              || (is_write && (addr == ADDR_CHSEL) && (ch_bad || busy_q))
              || (is_write && (addr == ADDR_RANGE) && (rg_bad || busy_q));
    pulse_trig = is_afe_rst || ar_start || ar_up || ar_down;
  end

`ifdef METER_CTRL_AUTORANGE_EN
  typedef enum logic [1:0] {
    AR_IDLE,
    AR_SETTLE,
    AR_CHECK,
    AR_DONE
  } ar_state_t;

  // The settle counter leaves SETTLE when it is about to reach zero, so a
  // settle-plus-check step lasts SETTLE_CYC+1 cycles.
  localparam int              SC_W        = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYC);

  ar_state_t       ar_state;
  logic [SC_W-1:0] settle_cnt;

  // Auto-range decisions: start/reject on frames, step or finish in CHECK.
  always_comb begin
    ar_start  = is_autorange && !busy_q;
    ar_reject = is_autorange && busy_q;
    ar_fault  = (ar_state == AR_CHECK) && sat_hi_i && sat_lo_i;
    ar_up     = (ar_state == AR_CHECK) && sat_hi_i && !sat_lo_i && (range_sel_o != RANGE_TOP);
    ar_down   = (ar_state == AR_CHECK) && sat_lo_i && !sat_hi_i && (range_sel_o != '0);
  end

  // Auto-range sequencer: settle after every range change, then inspect the flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ar_state   <= AR_IDLE;
      settle_cnt <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (ar_start) begin
            busy_q     <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            ar_state   <= (SETTLE_CYC == 0) ? AR_CHECK : AR_SETTLE;
          end
        end
        AR_SETTLE: begin
          if (settle_cnt <= SC_W'(1)) begin
            ar_state <= AR_CHECK;
          end
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SC_W'(1);
          end
        end
        AR_CHECK: begin
          if (ar_up || ar_down) begin
            settle_cnt <= SETTLE_LOAD;
            ar_state   <= (SETTLE_CYC == 0) ? AR_CHECK : AR_SETTLE;
          end else begin
            ar_state <= AR_DONE;
          end
        end
        AR_DONE: begin
          busy_q   <= 1'b0;
          ar_state <= AR_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          ar_state <= AR_IDLE;
        end
      endcase
    end
  end
`else
  // No sequencer in this build: AUTORANGE frames fall through as illegal.
  always_comb begin
    busy_q    = 1'b0;
    ar_start  = 1'b0;
    ar_reject = is_autorange;
    ar_fault  = 1'b0;
    ar_up     = 1'b0;
    ar_down   = 1'b0;
  end
`endif

  assign busy_o = busy_q;

  // Register file, sticky error flag and the READ response handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ref_sign_o  <= 1'b0;
      afe_sel_o   <= '0;
      range_sel_o <= RANGE_TOP;
      err_o       <= 1'b0;
      tx_data_o   <= '0;
      tx_wren_o   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ref_sign_o <= wdata[0];
      end
      if (wr_chsel) begin
        afe_sel_o <= wdata[CH_W-1:0];
      end
      if (wr_range) begin
        range_sel_o <= wdata[RG_W-1:0];
      end else if (ar_up) begin
        range_sel_o <= range_sel_o + RG_W'(1);
      end else if (ar_down) begin
        range_sel_o <= range_sel_o - RG_W'(1);
      end
      if (frame_err || ar_fault) begin
        err_o <= 1'b1;
      end else if (wr_ctrl) begin
        err_o <= 1'b0;
      end
      if (is_read) begin
        tx_data_o <= DW'(read_value);
        tx_wren_o <= 1'b1;
      end else if (tx_ack_i) begin
        tx_wren_o <= 1'b0;
      end
    end
  end

  // Integrator reset pulse generator; a new trigger restarts the full width.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      afe_reset_o <= 1'b0;
      rst_cnt     <= '0;
    end else if (pulse_trig) begin
      afe_reset_o <= 1'b1;
      rst_cnt     <= RST_LOAD;
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - RC_W'(1);
    end else begin
      afe_reset_o <= 1'b0;
    end
  end

endmodule
